bus_wait_gen: RTL and testbench
===============================

Name: bus_wait_gen

Overview:
- Parametrised Z80 bus wait-state generator; successor to the fixed one-T-state M1 wait flip-flop pair.
- Classifies each CPU bus cycle (M1 fetch, memory, I/O, interrupt acknowledge) and inserts a runtime-programmable number of wait T-states per class.
- Merges NUM_EXT external wait requests (slots, SDRAM, peripherals) into the single WAIT_n driven to t80pa.
- Keeps a saturating count of inserted wait states for debug and turbo tuning.

Parameters:
- CNT_W, 4: width of per-class wait counts; 0..2^CNT_W-1 T-states.
- NUM_EXT, 2: number of external active-low wait inputs.
- STAT_W, 16: width of the inserted-wait statistics counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- clk_en  in  1  CPU T-state enable (clk_en_3m58_p); all sampling and counting happens only on cycles where it is high.
- m1_n  in  1  CPU M1.
- mreq_n  in  1  CPU MREQ.
- iorq_n  in  1  CPU IORQ.
- rfsh_n  in  1  CPU RFSH.
- m1_waits  in  CNT_W  wait T-states for opcode fetch.
- mem_waits  in  CNT_W  wait T-states for non-M1 memory cycles.
- io_waits  in  CNT_W  wait T-states for I/O cycles and interrupt acknowledge.
- turbo  in  1  1 = internal waits suppressed; external waits still honoured.
- exwait_n  in  NUM_EXT  external wait requests, active-low, same clock domain.
- stat_clr  in  1  synchronous clear of wait_count.
- wait_n  out  1  to CPU WAIT_n.
- busy  out  1  internal wait counter non-zero.
- cycle_type  out  2  last classified cycle: 0 M1, 1 MEM, 2 IO, 3 INTA.
- wait_count  out  STAT_W  saturating count of clk_en periods with wait_n low.

Behaviour:
- Reset values: wait_n=1, busy=0, cycle_type=0, wait_count=0, internal counter=0, stored idle flag=1.
- idle = mreq_n & iorq_n. The idle flag is registered on each clk_en.
- Cycle start = clk_en & stored idle flag=1 & idle=0 & rfsh_n=1. Refresh cycles never start a wait.
- Classification at start, highest priority first:
  - m1_n=0 & iorq_n=0 → INTA.
  - m1_n=0 & mreq_n=0 → M1.
  - iorq_n=0 → IO.
  - otherwise → MEM.
- At start, load the counter with the class value: M1 → m1_waits, MEM → mem_waits, IO and INTA → io_waits. If turbo=1, load 0. cycle_type is updated on the same clk edge.
- Config inputs are sampled only at start. Changes mid-cycle take effect on the next cycle.
- Counter decrements by 1 on each clk_en while non-zero. busy = (counter != 0), registered.
- Internal wait: int_wait_n is a register, set to ~(counter_next != 0) on the start edge and on every decrement edge. It goes low on the clk edge of the start clk_en and stays low for exactly N clk_en periods. N=0 gives no low pulse.
- Default m1_waits=1 reproduces the legacy one-T-state M1 wait.
- wait_n = int_wait_n & AND-reduction of exwait_n. This path is combinational, so external requests add zero latency.
- Abort: if idle=1 is sampled on a clk_en while counter != 0, the counter clears to 0 and int_wait_n goes to 1 on that edge.
- A new start while counter != 0 (not legal Z80 behaviour) reloads the counter per the rules above.
- Statistics: on each clk_en with wait_n=0, wait_count increments and saturates at all-ones.
  - stat_clr has priority over increment.
  - stat_clr and increment on the same edge → result 0.
- Reset asserted mid-cycle forces the reset values immediately. After release, the next start is detected only after idle=1 has been sampled once.

Test Plan:
- M1 fetch, m1_waits=1, mem_waits=0, exwait_n all 1 → wait_n low for exactly 1 clk_en period starting at the edge where mreq_n is first sampled low; cycle_type=0; wait_count=1.
- I/O write, io_waits=3 → wait_n low for 3 clk_en periods; busy high for the same span; cycle_type=2; wait_count +3.
- Refresh (mreq_n=0, rfsh_n=0), mem_waits=5 → wait_n stays 1; cycle_type unchanged.
- turbo=1, m1_waits=2, exwait_n[1] pulled low for 4 clk_en periods during the fetch → wait_n low exactly while exwait_n[1]=0 (4 periods), zero-cycle latency; counter stays 0.
- mem_waits=7 with mreq_n deasserted after 2 clk_en periods → wait_n returns to 1 on the next clk_en edge; busy=0; next memory cycle reloads 7.
- wait_count preset to 0xFFFE, then 3 wait periods → saturates at 0xFFFF; stat_clr pulse → 0; reset asserted mid-wait → wait_n=1 immediately.

Source files
------------

// File: rtl/bus_wait_gen_if.sv
// Z80 bus control strobes plus the merged WAIT_n returned to the CPU.
// Purely a wiring bundle: no storage, no latency.
// No backpressure of its own; WAIT_n is the CPU's only stall mechanism.
interface bus_wait_gen_if;
    logic m1_n;
    logic mreq_n;
    logic iorq_n;
    logic rfsh_n;
    logic wait_n;

    // CPU side: drives the bus strobes, receives WAIT_n.
    modport master (
        output m1_n,
        output mreq_n,
        output iorq_n,
        output rfsh_n,
        input  wait_n
    );

    // Wait generator side: observes the strobes, drives WAIT_n.
    modport slave (
        input  m1_n,
        input  mreq_n,
        input  iorq_n,
        input  rfsh_n,
        output wait_n
    );
endinterface

// File: rtl/bus_wait_gen.sv
// Z80 wait-state generator: per-class programmable waits merged with external wait requests.
// Latency: internal wait asserts on the clk edge of the cycle-start clk_en; external waits are combinational.
// Backpressure: stalls the CPU through WAIT_n; the block itself never stalls.
module bus_wait_gen #(
    parameter int CNT_W   = 4,
    parameter int NUM_EXT = 2,
    parameter int STAT_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_en,
    bus_wait_gen_if.slave      bus,
    input  logic [CNT_W-1:0]   m1_waits,
    input  logic [CNT_W-1:0]   mem_waits,
    input  logic [CNT_W-1:0]   io_waits,
    input  logic               turbo,
    input  logic [NUM_EXT-1:0] exwait_n,
    input  logic               stat_clr,
    output logic               busy,
    output logic [1:0]         cycle_type,
    output logic [STAT_W-1:0]  wait_count
);

    typedef enum logic [1:0] {
        CYC_M1   = 2'd0,
        CYC_MEM  = 2'd1,
        CYC_IO   = 2'd2,
        CYC_INTA = 2'd3
    } cyc_t;

    logic             idle;
    logic             idle_q;
    logic             start;
    cyc_t             cls;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             int_wait_n;
    logic             wait_n;

    // A bus cycle begins when the bus leaves idle; refresh cycles are excluded.
    assign idle  = bus.mreq_n & bus.iorq_n;
    assign start = clk_en & idle_q & ~idle & bus.rfsh_n;

    // Classify the cycle (INTA beats M1 because both assert M1) and pick its wait budget.
    always_comb begin
        cls      = CYC_MEM;
        load_val = mem_waits;
        if (!bus.m1_n && !bus.iorq_n) begin
            cls      = CYC_INTA;
            load_val = io_waits;
        end else if (!bus.m1_n && !bus.mreq_n) begin
            cls      = CYC_M1;
            load_val = m1_waits;
        end else if (!bus.iorq_n) begin
            cls      = CYC_IO;
            load_val = io_waits;
        end
        if (turbo) begin
            load_val = '0;
        end
    end

    // Counter next value: load on start, clear if the bus went idle early, else count down.
    always_comb begin
        cnt_next = cnt;
        if (start) begin
            cnt_next = load_val;
        end else if (clk_en && (cnt != '0)) begin
            if (idle) begin
                cnt_next = '0;
            end else begin
                cnt_next = cnt - CNT_W'(1);
            end
        end
    end

    // Bus-idle history, wait counter and the registered internal wait / busy flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_q     <= 1'b1;
            cnt        <= '0;
            int_wait_n <= 1'b1;
            busy       <= 1'b0;
            cycle_type <= CYC_M1;
        end else begin
            if (clk_en) begin
                idle_q     <= idle;
                cnt        <= cnt_next;
                int_wait_n <= ~(cnt_next != '0);
                busy       <= (cnt_next != '0);
            end
            if (start) begin
                cycle_type <= cls;
            end
        end
    end

    // External requests bypass the registers so they stall the CPU with no added latency.
    assign wait_n     = int_wait_n & (&exwait_n);
    assign bus.wait_n = wait_n;

    // Saturating count of T-states spent waiting; a clear wins over a coincident increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_count <= '0;
        end else if (clk_en) begin
            if (stat_clr) begin
                wait_count <= '0;
            end else if (!wait_n && !(&wait_count)) begin
                wait_count <= wait_count + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bus_wait_gen.sv
// Directed self-checking bench for bus_wait_gen.
// Inputs change and outputs are sampled 1ns after each rising clk edge.
// Every expected value below is hand-derived from the intended behaviour.
module tb_bus_wait_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic [3:0]  m1_waits;
    logic [3:0]  mem_waits;
    logic [3:0]  io_waits;
    logic        turbo;
    logic [1:0]  exwait_n;
    logic        stat_clr;
    logic        busy;
    logic [1:0]  cycle_type;
    logic [15:0] wait_count;

    int tests  = 0;
    int failed = 0;

    bus_wait_gen_if bus ();

    bus_wait_gen #(
        .CNT_W   (4),
        .NUM_EXT (2),
        .STAT_W  (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .bus        (bus.slave),
        .m1_waits   (m1_waits),
        .mem_waits  (mem_waits),
        .io_waits   (io_waits),
        .turbo      (turbo),
        .exwait_n   (exwait_n),
        .stat_clr   (stat_clr),
        .busy       (busy),
        .cycle_type (cycle_type),
        .wait_count (wait_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        bus.m1_n   = 1'b1;
        bus.mreq_n = 1'b1;
        bus.iorq_n = 1'b1;
        bus.rfsh_n = 1'b1;
    endtask

    initial begin
        reset     = 1'b1;
        clk_en    = 1'b1;
        m1_waits  = 4'd1;
        mem_waits = 4'd0;
        io_waits  = 4'd3;
        turbo     = 1'b0;
        exwait_n  = 2'b11;
        stat_clr  = 1'b0;
        bus_idle();
        tick();
        tick();
        chk("rst_wait_n", 32'(bus.wait_n), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cycle_type", 32'(cycle_type), 32'd0);
        chk("rst_wait_count", 32'(wait_count), 32'd0);
        reset = 1'b0;
        tick();

        // M1 fetch with one wait state
        bus.m1_n   = 1'b0;
        bus.mreq_n = 1'b0;
        tick();
        chk("m1_wait_low", 32'(bus.wait_n), 32'd0);
        chk("m1_busy", 32'(busy), 32'd1);
        chk("m1_cycle_type", 32'(cycle_type), 32'd0);
        tick();
        chk("m1_wait_release", 32'(bus.wait_n), 32'd1);
        chk("m1_busy_clear", 32'(busy), 32'd0);
        chk("m1_wait_count", 32'(wait_count), 32'd1);
        bus_idle();
        tick();

        // I/O cycle with three waits
        bus.iorq_n = 1'b0;
        tick();
        chk("io_cycle_type", 32'(cycle_type), 32'd2);
        for (int i = 0; i < 3; i++) begin
            chk("io_wait_low", 32'(bus.wait_n), 32'd0);
            chk("io_busy", 32'(busy), 32'd1);
            tick();
        end
        chk("io_wait_release", 32'(bus.wait_n), 32'd1);
        chk("io_busy_clear", 32'(busy), 32'd0);
        chk("io_wait_count", 32'(wait_count), 32'd4);
        bus_idle();
        tick();

        // Refresh never starts a wait and leaves cycle_type alone
        mem_waits  = 4'd5;
        bus.mreq_n = 1'b0;
        bus.rfsh_n = 1'b0;
        tick();
        chk("rfsh_wait_n", 32'(bus.wait_n), 32'd1);
        chk("rfsh_busy", 32'(busy), 32'd0);
        chk("rfsh_cycle_type", 32'(cycle_type), 32'd2);
        tick();
        chk("rfsh_wait_n2", 32'(bus.wait_n), 32'd1);
        bus_idle();
        tick();

        // Turbo fetch: internal waits suppressed, external wait passes straight through
        turbo      = 1'b1;
        m1_waits   = 4'd2;
        bus.m1_n   = 1'b0;
        bus.mreq_n = 1'b0;
        tick();
        chk("turbo_wait_n", 32'(bus.wait_n), 32'd1);
        chk("turbo_busy", 32'(busy), 32'd0);
        chk("turbo_cycle_type", 32'(cycle_type), 32'd0);
        exwait_n = 2'b01;
        #1;
        chk("ext_zero_latency", 32'(bus.wait_n), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ext_busy_zero", 32'(busy), 32'd0);
            chk("ext_wait_low", 32'(bus.wait_n), 32'd0);
        end
        exwait_n = 2'b11;
        #1;
        chk("ext_release", 32'(bus.wait_n), 32'd1);
        chk("ext_wait_count", 32'(wait_count), 32'd8);
        turbo = 1'b0;
        bus_idle();
        tick();

        // Memory cycle aborted early, then a full reload of seven waits
        mem_waits  = 4'd7;
        bus.mreq_n = 1'b0;
        tick();
        chk("mem_cycle_type", 32'(cycle_type), 32'd1);
        chk("mem_wait_low", 32'(bus.wait_n), 32'd0);
        tick();
        bus.mreq_n = 1'b1;
        tick();
        chk("abort_wait_n", 32'(bus.wait_n), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_wait_count", 32'(wait_count), 32'd10);
        bus.mreq_n = 1'b0;
        tick();
        mem_waits = 4'd2;
        chk("reload_busy", 32'(busy), 32'd1);
        repeat (6) tick();
        chk("reload_still_low", 32'(bus.wait_n), 32'd0);
        tick();
        chk("reload_release", 32'(bus.wait_n), 32'd1);
        chk("reload_wait_count", 32'(wait_count), 32'd17);
        bus_idle();
        tick();

        // clk_en low: no start, no counting, no statistics
        io_waits   = 4'd2;
        clk_en     = 1'b0;
        bus.iorq_n = 1'b0;
        tick();
        tick();
        chk("gate_no_start_wait", 32'(bus.wait_n), 32'd1);
        chk("gate_no_start_type", 32'(cycle_type), 32'd1);
        clk_en = 1'b1;
        tick();
        chk("gate_start_type", 32'(cycle_type), 32'd2);
        clk_en = 1'b0;
        repeat (3) tick();
        chk("gate_hold_busy", 32'(busy), 32'd1);
        chk("gate_hold_count", 32'(wait_count), 32'd17);
        clk_en = 1'b1;
        tick();
        tick();
        chk("gate_release", 32'(bus.wait_n), 32'd1);
        chk("gate_wait_count", 32'(wait_count), 32'd19);
        bus_idle();
        tick();

        // Statistics: clear beats increment, then saturation
        exwait_n = 2'b10;
        stat_clr = 1'b1;
        tick();
        chk("clr_priority", 32'(wait_count), 32'd0);
        stat_clr = 1'b0;
        repeat (65534) tick();
        chk("stat_fffe", 32'(wait_count), 32'h0000_fffe);
        repeat (3) tick();
        chk("stat_saturate", 32'(wait_count), 32'h0000_ffff);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        exwait_n = 2'b11;
        tick();
        chk("stat_clear", 32'(wait_count), 32'd0);

        // Reset in the middle of a wait
        io_waits   = 4'd5;
        bus.iorq_n = 1'b0;
        tick();
        tick();
        chk("pre_rst_wait_low", 32'(bus.wait_n), 32'd0);
        chk("pre_rst_count", 32'(wait_count), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_wait_n", 32'(bus.wait_n), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_cycle_type", 32'(cycle_type), 32'd0);
        chk("midrst_wait_count", 32'(wait_count), 32'd0);
        bus_idle();
        tick();
        reset = 1'b0;
        tick();
        m1_waits   = 4'd1;
        bus.m1_n   = 1'b0;
        bus.mreq_n = 1'b0;
        tick();
        chk("post_rst_wait_low", 32'(bus.wait_n), 32'd0);
        tick();
        chk("post_rst_release", 32'(bus.wait_n), 32'd1);
        chk("post_rst_count", 32'(wait_count), 32'd1);
        bus_idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
